qam_symbol_capture_ctrl: RTL
============================

// Module: qam_symbol_capture_ctrl
// PURPOSE
//   Parametrised successor to the hard-decision demapper controller, with the symbol FIFO built in.
//   Captures demapped QAM symbols into an internal FIFO and raises "available" once a frame threshold is reached.
//   Drains the FIFO to the host word by word on "read" strobes and signals "complete" when the frame is drained.
//   Optional overrun mode keeps capturing past the threshold; every symbol lost is counted.
// PARAMETERS
//   SYM_W     4    bits per demapped symbol (log2 M; 2=QPSK, 4=16QAM, 6=64QAM)
//   DEPTH     16   FIFO depth in symbols; power of two, >=4
//   FRAME_LEN 16   fill level that raises available; 1..DEPTH
//   DROP_W    8    width of the saturating drop counter
// PORTS
//   dclk        in   1              capture/host clock
//   reset_n     in   1              synchronous reset, active-low
//   enable      in   1              block enable; low forces IDLE and flushes the FIFO
//   overrun_en  in   1              1 = keep writing in READY until full; 0 = drop in READY
//   sym_valid   in   1              sym_in carries a valid symbol this cycle
//   sym_in      in   SYM_W          demapped symbol
//   read        in   1              host pop strobe, one word per cycle high
//   rd_data     out  SYM_W          popped symbol, registered
//   rd_valid    out  1              rd_data valid this cycle
//   available   out  1              frame ready for the host
//   complete    out  1              frame drained, or block idle
//   fill_level  out  log2(DEPTH)+1  current FIFO occupancy
//   drop_count  out  DROP_W         symbols discarded since reset or leaving IDLE; saturates at all-ones
//   state       out  2              FSM state: 00 IDLE, 01 RECEIVE, 10 READY, 11 READOUT
// BEHAVIOUR
//   Reset (reset_n=0 at a dclk edge)
//     - state=IDLE, pointers=0, fill_level=0, drop_count=0
//     - rd_valid=0, rd_data=0, available=0, complete=1
//     - reset has priority over everything else
//   Outputs: all registered; FSM is a single registered state plus next-state logic.
//   FIFO rules
//     - push = sym_valid & (state==RECEIVE | (state==READY & overrun_en)) & !full
//     - pop  = read & (state==READY | state==READOUT) & !empty
//     - pointers wrap modulo DEPTH; full at fill_level==DEPTH
//     - push and pop in the same cycle: fill_level unchanged
//     - pop: rd_data <= head and rd_valid=1 on the next cycle (latency 1); otherwise rd_valid=0 and rd_data holds
//   Drops: drop_count increments when sym_valid=1 and no push happens while state!=IDLE (full, READY with overrun_en=0, or READOUT).
//   FSM (enable=0 from any state -> IDLE, flush pointers, drop_count kept)
//     - IDLE: complete=1, available=0
//         enable=1 -> RECEIVE; drop_count clears on this transition
//     - RECEIVE: fill level counts the push in this cycle
//         fill_level after push >= FRAME_LEN -> READY; available=1, complete=0 the next cycle
//     - READY: read=1 -> READOUT; the same cycle's read also pops
//     - READOUT:
//         pop that empties the FIFO, or FIFO already empty -> RECEIVE; available=0, complete=1
//         read=0 in READOUT: stay, no pop, no timeout
//   complete stays 1 until the next READY entry
//   read while empty, or in IDLE/RECEIVE: ignored, rd_valid=0
//   enable falling mid-READOUT: in-flight rd_valid still completes the next cycle, then FIFO empty
// TESTING
//   1 Reset: hold reset_n=0 with enable=1, sym_valid=1 -> state=00, fill_level=0, available=0, complete=1, drop_count=0.
//   2 Frame: SYM_W=4, DEPTH=16, FRAME_LEN=8; push 8 symbols 0..7 -> available=1 the cycle after the 8th;
//     8 read strobes -> rd_data 0..7, each 1 cycle after its strobe; complete=1, state=01 after the last.
//   3 No overrun: overrun_en=0; push 8, then 5 more valid symbols in READY -> drop_count=5, fill_level=8.
//   4 Overrun: overrun_en=1; 20 symbols -> fill_level=16, drop_count=4; drain yields 0..15 in order.
//   5 Wrap and simultaneous: run 3 frames back to back -> pointers wrap and data stays ordered;
//     push and pop in one cycle in READY with overrun_en=1 -> fill_level unchanged.
//   6 Abort: enable=0 mid-READOUT with 4 words left -> state=00 the next cycle, fill_level=0, complete=1, drop_count kept.

Source files
------------

// File: rtl/qam_symbol_capture_ctrl.sv
// qam_symbol_capture_ctrl: captures demapped QAM symbols into a FIFO and drains a frame to the host.
module qam_symbol_capture_ctrl #(
  parameter int SYM_W     = 4,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 16,
  parameter int DROP_W    = 8
) (
  input  logic                     dclk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     overrun_en,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym_in,
  input  logic                     read,
  output logic [SYM_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     available,
  output logic                     complete,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [DROP_W-1:0]        drop_count,
  output logic [1:0]               state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FL = (AW+1)'(FRAME_LEN);
  localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, RECEIVE, READY, READOUT} state_t;
  state_t st, nst;
  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fill_nxt;
  logic full, empty, push, pop, drop;
  assign state = st;
  assign full  = fill_level == FULL_L;
  assign empty = fill_level == '0;
  assign push  = sym_valid & (st == RECEIVE | (st == READY & overrun_en)) & !full;
  assign pop   = read & (st == READY | st == READOUT) & !empty;
  assign drop  = sym_valid & !push & (st != IDLE);
  always_comb begin
    fill_nxt = (push & !pop) ? fill_level + (AW+1)'(1) :
               (pop & !push) ? fill_level - (AW+1)'(1) : fill_level;
    nst = st;
    if (!enable) nst = IDLE;
    else
      case (st)
        IDLE:    nst = RECEIVE;
        RECEIVE: nst = (fill_nxt >= FL) ? READY : RECEIVE;
        READY:   nst = read ? READOUT : READY;
        default: nst = (fill_nxt == '0) ? RECEIVE : READOUT;
      endcase
  end
  always_ff @(posedge dclk) if (push) mem[wr_ptr] <= sym_in;
  always_ff @(posedge dclk) begin
    if (!reset_n) begin
      st         <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      drop_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      available  <= 1'b0;
      complete   <= 1'b1;
    end else begin
      st        <= nst;
      available <= nst == READY || nst == READOUT;
      complete  <= !(nst == READY || nst == READOUT);
      rd_valid  <= pop;
      if (pop) rd_data <= mem[rd_ptr];
      // a pop issued in the abort cycle still delivers its word; the FIFO is flushed behind it
      if (!enable) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fill_level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fill_level <= fill_nxt;
      end
      if (st == IDLE && enable) drop_count <= '0;
      else if (drop && drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end
endmodule
